// File: rtl/valid_ready_sram.sv
// Single-port synchronous RAM behind a valid/ready request port.
// One write or read per cycle; registered read data with 1-cycle latency.
module valid_ready_sram #(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 1024,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic [WIDTH-1:0]      rd_data_o,
  input  logic                  valid_i,
  output logic                  ready_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;
  logic             accept;

  // Only non-power-of-2 depths can see addresses past the end
  if ((1 << ADDR_WIDTH) == DEPTH) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
    assign in_range = {1'b0, addr_i} < LIMIT;
  end

  assign accept = valid_i && ready_o;

  always_ff @(posedge clk) begin
    ready_o <= ~rst;
    if (rst) begin
      rd_data_o <= '0;
    end else if (accept && !wr_rd_i) begin
      rd_data_o <= in_range ? mem[addr_i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept && wr_rd_i && in_range) begin
      mem[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_valid_ready_sram.sv
// Directed bench for valid_ready_sram: vector table plus
// full-array write/read sweep and idle-hold sequence.
module tb_valid_ready_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr_i;
  logic        wr_rd_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic        valid_i;
  logic        ready_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [1024];

  typedef struct {
    logic        rst;
    logic        valid;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl [19];

  valid_ready_sram dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .wr_rd_i   (wr_rd_i),
    .wr_data_i (wr_data_i),
    .rd_data_o (rd_data_o),
    .valid_i   (valid_i),
    .ready_o   (ready_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic v, input logic w,
                       input logic [9:0] a, input logic [31:0] d);
    rst       = r;
    valid_i   = v;
    wr_rd_i   = w;
    addr_i    = a;
    wr_data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] rd,
                       input logic rdy);
    n_vec++;
    if (rd_data_o !== rd || ready_o !== rdy) begin
      n_err++;
      $display("FAIL %s: rd_data_o=%h ready_o=%b, expected rd_data_o=%h ready_o=%b",
               name, rd_data_o, ready_o, rd, rdy);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 10'd0,    32'h0,        32'h0,        1};
    tbl[1]  = '{0, 1, 1, 10'd5,    32'hDEADBEEF, 32'h0,        1};
    tbl[2]  = '{0, 1, 0, 10'd5,    32'h0,        32'hDEADBEEF, 1};
    tbl[3]  = '{0, 1, 1, 10'd6,    32'h11111111, 32'hDEADBEEF, 1};
    tbl[4]  = '{0, 1, 1, 10'd1023, 32'h12345678, 32'hDEADBEEF, 1};
    tbl[5]  = '{0, 1, 0, 10'd1023, 32'h0,        32'h12345678, 1};
    tbl[6]  = '{0, 1, 0, 10'd0,    32'h0,        32'h0,        1};
    tbl[7]  = '{0, 1, 1, 10'd0,    32'hCAFEF00D, 32'h0,        1};
    tbl[8]  = '{0, 1, 0, 10'd0,    32'h0,        32'hCAFEF00D, 1};
    tbl[9]  = '{0, 1, 0, 10'd6,    32'h0,        32'h11111111, 1};
    tbl[10] = '{0, 0, 1, 10'd6,    32'hFFFFFFFF, 32'h11111111, 1};
    tbl[11] = '{0, 0, 0, 10'd5,    32'h0,        32'h11111111, 1};
    tbl[12] = '{0, 1, 0, 10'd6,    32'h0,        32'h11111111, 1};
    tbl[13] = '{0, 1, 1, 10'd7,    32'hA5A5A5A5, 32'h11111111, 1};
    tbl[14] = '{1, 1, 1, 10'd8,    32'h55555555, 32'h0,        0};
    tbl[15] = '{0, 1, 0, 10'd7,    32'h0,        32'h0,        1};
    tbl[16] = '{0, 1, 0, 10'd7,    32'h0,        32'h0,        1};
    tbl[17] = '{0, 1, 0, 10'd8,    32'h0,        32'h0,        1};
    tbl[18] = '{0, 1, 0, 10'd5,    32'h0,        32'h0,        1};

    rst = 1'b1; valid_i = 1'b0; wr_rd_i = 1'b0;
    addr_i = '0; wr_data_i = '0;

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 10'd0, 32'h0);
      check($sformatf("reset_%0d", i), 32'h0, 1'b0);
    end

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      check($sformatf("vec_%0d", i), tbl[i].exp_rd, tbl[i].exp_rdy);
    end

    // full sweep; rd_data_o still 0 from the last table read
    for (int a = 0; a < 1024; a++) begin
      model[a] = $urandom;
      drive(0, 1, 1, 10'(a), model[a]);
    end
    check("sweep_wr_hold", 32'h0, 1'b1);
    for (int a = 0; a < 1024; a++) begin
      drive(0, 1, 0, 10'(a), 32'h0);
      check($sformatf("sweep_rd_%0d", a), model[a], 1'b1);
    end

    // idle traffic must neither write nor disturb read data
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1'(i), 10'(i * 97), $urandom);
      check($sformatf("idle_%0d", i), model[1023], 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 10'(i * 97), 32'h0);
      check($sformatf("idle_rb_%0d", i), model[i * 97], 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
